// File: rtl/ex_wb_stage_pkg.sv
// Shared definitions for the execute-to-writeback stage: flag bit positions,
// branch condition encodings and the condition evaluator.
package ex_wb_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_AL  = 3'b111;

    // Encodings 100..110 are reserved and never taken.
    function automatic logic cond_true(input logic [2:0] c, input logic [3:0] f);
        logic lt;
        lt = f[FLAG_S] ^ f[FLAG_V];
        case (c)
            COND_BE:  return f[FLAG_Z];
            COND_BLT: return lt;
            COND_BLE: return f[FLAG_Z] | lt;
            COND_BNE: return ~f[FLAG_Z];
            COND_AL:  return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_wb_stage_fifo.sv
// Two-entry queue between execute and register-file writeback.
// Flush wins over a same-cycle push or pop; storage is cleared only by reset.
module wb_skid_fifo #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         head;
    logic         tail;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop && (count != 2'd0);
    assign rdata   = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[tail] <= wdata;
                tail      <= ~tail;
            end
            if (pop_ok) begin
                head <= ~head;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: queues results for the register file, owns the
// architectural S/Z/C/V register and evaluates branch conditions from it.
module ex_wb_stage
    import ex_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_res,
    input  logic [3:0]        in_szcv,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic              in_fe,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic [3:0]        flags,
    input  logic [2:0]        cond,
    output logic              take
);

    localparam int PW = DATA_W + REG_AW + 1;

    logic [PW-1:0] head_entry;
    logic [1:0]    count;
    logic          push;
    logic          pop;
    logic          head_we;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    wb_skid_fifo #(.W(PW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({in_res, in_rd, in_we}),
        .rdata (head_entry),
        .count (count)
    );

    assign {out_res, out_rd, head_we} = head_entry;
    assign out_we = head_we && out_valid;

    // Flags commit when the result is accepted, so a later flush cannot undo them.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (push && in_fe) begin
            flags <= in_szcv;
        end
    end

    assign take = cond_true(cond, flags);

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed, table-driven bench for ex_wb_stage with hand-computed expectations.
module tb_ex_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_res;
    logic [3:0]  in_szcv;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        in_fe;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [2:0]  out_rd;
    logic        out_we;
    logic [3:0]  flags;
    logic [2:0]  cond;
    logic        take;

    int checks = 0;
    int failures = 0;

    ex_wb_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_szcv   (in_szcv),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .in_fe     (in_fe),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .flags     (flags),
        .cond      (cond),
        .take      (take)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] res;
        logic [3:0]  szcv;
        logic [2:0]  rd;
        logic        we;
        logic        fe;
        logic        fl;
        logic        ordy;
        logic [2:0]  c;
        logic        e_irdy;
        logic        e_ovld;
        logic        e_owe;
        logic        chk_data;
        logic [15:0] e_res;
        logic [2:0]  e_rd;
        logic [3:0]  e_flags;
        logic        e_take;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [15:0] res, input logic [3:0] szcv,
                       input logic [2:0] rd, input logic we, input logic fe,
                       input logic fl, input logic ordy, input logic [2:0] c,
                       input logic e_irdy, input logic e_ovld, input logic e_owe,
                       input logic chk_data, input logic [15:0] e_res,
                       input logic [2:0] e_rd, input logic [3:0] e_flags,
                       input logic e_take);
        vec_t t;
        t.v = v; t.res = res; t.szcv = szcv; t.rd = rd; t.we = we; t.fe = fe;
        t.fl = fl; t.ordy = ordy; t.c = c;
        t.e_irdy = e_irdy; t.e_ovld = e_ovld; t.e_owe = e_owe;
        t.chk_data = chk_data; t.e_res = e_res; t.e_rd = e_rd;
        t.e_flags = e_flags; t.e_take = e_take;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_res = '0; in_szcv = '0; in_rd = '0;
        in_we = 1'b0; in_fe = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        cond = 3'b011;

        //   v  res      szcv     rd    we fe fl ordy cond    irdy ovld owe chk res      rd    flags    take
        add(1, 16'h8001, 4'b1000, 3'd3, 1, 1, 0, 1, 3'b001, 1, 1, 1, 1, 16'h8001, 3'd3, 4'b1000, 1);
        add(0, 16'h0000, 4'b0000, 3'd0, 0, 0, 0, 1, 3'b001, 1, 0, 0, 0, 16'h0000, 3'd0, 4'b1000, 1);
        add(1, 16'h000A, 4'b0000, 3'd1, 1, 0, 0, 0, 3'b000, 1, 1, 1, 1, 16'h000A, 3'd1, 4'b1000, 0);
        add(1, 16'h000B, 4'b0000, 3'd2, 0, 0, 0, 0, 3'b000, 0, 1, 1, 1, 16'h000A, 3'd1, 4'b1000, 0);
        // full: third result refused, its flags must not land
        add(1, 16'h000C, 4'b0010, 3'd4, 1, 1, 0, 0, 3'b011, 0, 1, 1, 1, 16'h000A, 3'd1, 4'b1000, 1);
        add(1, 16'h000C, 4'b0010, 3'd4, 1, 1, 0, 1, 3'b011, 1, 1, 0, 1, 16'h000B, 3'd2, 4'b1000, 1);
        add(1, 16'h000C, 4'b0010, 3'd4, 1, 1, 0, 1, 3'b010, 1, 1, 1, 1, 16'h000C, 3'd4, 4'b0010, 0);
        add(0, 16'h0000, 4'b0000, 3'd0, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 16'h0000, 3'd0, 4'b0010, 0);
        add(1, 16'h000D, 4'b0000, 3'd5, 1, 0, 0, 0, 3'b000, 1, 1, 1, 1, 16'h000D, 3'd5, 4'b0010, 0);
        add(1, 16'h000E, 4'b0000, 3'd6, 1, 0, 0, 0, 3'b000, 0, 1, 1, 1, 16'h000D, 3'd5, 4'b0010, 0);
        add(0, 16'h0000, 4'b0000, 3'd0, 0, 0, 1, 1, 3'b000, 1, 0, 0, 0, 16'h0000, 3'd0, 4'b0010, 0);
        add(1, 16'h00D0, 4'b0000, 3'd5, 1, 0, 0, 0, 3'b000, 1, 1, 1, 1, 16'h00D0, 3'd5, 4'b0010, 0);
        // flush with accepted push: entry dropped, flags still commit
        add(1, 16'h00F0, 4'b0100, 3'd7, 1, 1, 1, 0, 3'b000, 1, 0, 0, 0, 16'h0000, 3'd0, 4'b0100, 1);
        add(1, 16'h0001, 4'b0010, 3'd1, 1, 1, 0, 1, 3'b100, 1, 1, 1, 1, 16'h0001, 3'd1, 4'b0010, 0);
        add(1, 16'h0002, 4'b1111, 3'd2, 0, 0, 0, 1, 3'b111, 1, 1, 0, 1, 16'h0002, 3'd2, 4'b0010, 1);
        add(0, 16'h0000, 4'b0000, 3'd0, 0, 0, 0, 1, 3'b100, 1, 0, 0, 0, 16'h0000, 3'd0, 4'b0010, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_flags", -1, 32'(flags), 32'h0);
        check("rst_out_valid", -1, 32'(out_valid), 32'h0);
        check("rst_in_ready", -1, 32'(in_ready), 32'h1);
        check("rst_out_we", -1, 32'(out_we), 32'h0);
        check("rst_out_res", -1, 32'(out_res), 32'h0);
        check("rst_out_rd", -1, 32'(out_rd), 32'h0);
        check("rst_take_bne", -1, 32'(take), 32'h1);
        cond = 3'b000;
        #1;
        check("rst_take_be", -1, 32'(take), 32'h0);

        foreach (vecs[i]) begin
            in_valid = vecs[i].v; in_res = vecs[i].res; in_szcv = vecs[i].szcv;
            in_rd = vecs[i].rd; in_we = vecs[i].we; in_fe = vecs[i].fe;
            flush = vecs[i].fl; out_ready = vecs[i].ordy; cond = vecs[i].c;
            @(posedge clk);
            #1;
            check("in_ready", i, 32'(in_ready), 32'(vecs[i].e_irdy));
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ovld));
            check("out_we", i, 32'(out_we), 32'(vecs[i].e_owe));
            check("flags", i, 32'(flags), 32'(vecs[i].e_flags));
            check("take", i, 32'(take), 32'(vecs[i].e_take));
            if (vecs[i].chk_data) begin
                check("out_res", i, 32'(out_res), 32'(vecs[i].e_res));
                check("out_rd", i, 32'(out_rd), 32'(vecs[i].e_rd));
            end
        end

        // Reset while the queue is full and flags are set.
        idle_inputs();
        in_valid = 1'b1; in_res = 16'h1234; in_rd = 3'd6; in_we = 1'b1;
        in_fe = 1'b1; in_szcv = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_flags", 100, 32'(flags), 32'hF);
        check("pre_rst_in_ready", 100, 32'(in_ready), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        cond = 3'b000;
        #1;
        check("mid_rst_out_valid", 101, 32'(out_valid), 32'h0);
        check("mid_rst_in_ready", 101, 32'(in_ready), 32'h1);
        check("mid_rst_flags", 101, 32'(flags), 32'h0);
        check("mid_rst_out_res", 101, 32'(out_res), 32'h0);
        check("mid_rst_out_rd", 101, 32'(out_rd), 32'h0);
        check("mid_rst_out_we", 101, 32'(out_we), 32'h0);
        check("mid_rst_take", 101, 32'(take), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
